// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
package f1_pkg;

  typedef enum logic [1:0] {IDLE, FILL, HOLD, TIMING} f1_state_t;

  // Feedback mask for the 7-bit hold-delay LFSR: x^7 + x^3 + 1 (bits 6 and 2).
  localparam logic [31:0] LFSR_TAPS_7 = 32'h0000_0044;

  // Every power-up starts the LFSR here; it must be non-zero.
  localparam int unsigned LFSR_SEED = 1;

  // Maximal-length feedback masks for common widths. Every mask includes
  // the top bit, so the shift is invertible and a non-zero state never
  // collapses to zero, even for widths that fall back to the default.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return LFSR_TAPS_7;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      default: return (32'd1 << (w - 1)) | (32'd1 << (w - 2));
    endcase
  endfunction

endpackage

// File: rtl/f1_start_seq_if.sv
// Control/status bundle between the button inputs and the LED bar / display.
interface f1_start_seq_if #(
  parameter int N_LIGHTS = 8,
  parameter int WIDTH    = 16,
  parameter int TIME_W   = 16
);
  logic                en;
  logic [WIDTH-1:0]    N;
  logic                trigger;
  logic                react;
  logic                tick;
  logic [N_LIGHTS-1:0] data_out;
  logic                busy;
  logic                done;
  logic                jump;
  logic [TIME_W-1:0]   react_time;

  modport master (
    output en, N, trigger, react,
    input  tick, data_out, busy, done, jump, react_time
  );

  modport slave (
    input  en, N, trigger, react,
    output tick, data_out, busy, done, jump, react_time
  );
endinterface

// File: rtl/f1_prescaler.sv
// Reloadable down-counter producing a one-cycle step tick every N+1 enabled cycles.
module f1_prescaler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] N,
  input  logic             restart,
  output logic             tick
);

  logic [WIDTH-1:0] cnt;

  assign tick = en && (cnt == '0);

  // Reload on restart or terminal count; otherwise count down while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= N;
    end else if (en) begin
      cnt <= (cnt == '0) ? N : cnt - WIDTH'(1);
    end
  end

endmodule

// File: rtl/f1_start_seq.sv
// F1 start-light sequencer: fill lights per tick, random hold, lights out,
// then time the driver's reaction in clock cycles; early presses are jump starts.
module f1_start_seq
  import f1_pkg::*;
#(
  parameter int N_LIGHTS = 8,
  parameter int WIDTH    = 16,
  parameter int LFSR_W   = 7,
  parameter int TIME_W   = 16
) (
  input logic           clk,
  input logic           rst,
  f1_start_seq_if.slave bus
);

  localparam logic [LFSR_W-1:0]   TAPS   = LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [LFSR_W-1:0]   SEED   = LFSR_W'(LFSR_SEED);
  localparam logic [N_LIGHTS-1:0] ALL_ON = '1;

  f1_state_t           state;
  logic [N_LIGHTS-1:0] lights;
  logic [N_LIGHTS-1:0] lights_next;
  logic [LFSR_W-1:0]   lfsr;
  logic [LFSR_W-1:0]   hold_cnt;
  logic [TIME_W-1:0]   timer;
  logic [TIME_W-1:0]   rtime;
  logic                done_r;
  logic                jump_r;
  logic                tick;
  logic                restart;

  // Increment that sticks at all ones instead of wrapping.
  function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
    return (v == '1) ? v : v + TIME_W'(1);
  endfunction

  assign restart     = (state == IDLE) && bus.trigger;
  assign lights_next = {lights[N_LIGHTS-2:0], 1'b1};

  f1_prescaler #(.WIDTH(WIDTH)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .N       (bus.N),
    .restart (restart),
    .tick    (tick)
  );

  assign bus.tick       = tick;
  assign bus.data_out   = lights;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_r;
  assign bus.jump       = jump_r;
  assign bus.react_time = rtime;

  // Free-running hold-delay source, clocked every cycle regardless of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
    end
  end

  // Sequencer: fill, hold, time the reaction; react beats a coincident tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lights   <= '0;
      done_r   <= 1'b0;
      jump_r   <= 1'b0;
      rtime    <= '0;
      hold_cnt <= '0;
      timer    <= '0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.trigger) begin
            jump_r <= 1'b0;
            lights <= '0;
            state  <= FILL;
          end
        end
        FILL, HOLD: begin
          if (bus.react) begin
            lights <= '0;
            jump_r <= 1'b1;
            rtime  <= '0;
            done_r <= 1'b1;
            state  <= IDLE;
          end else if (tick) begin
            if (state == FILL) begin
              lights <= lights_next;
              if (lights_next == ALL_ON) begin
                hold_cnt <= lfsr;
                state    <= HOLD;
              end
            end else if (hold_cnt == LFSR_W'(1)) begin
              lights <= '0;
              timer  <= '0;
              state  <= TIMING;
            end else begin
              hold_cnt <= hold_cnt - LFSR_W'(1);
            end
          end
        end
        TIMING: begin
          timer <= sat_inc(timer);
          if (bus.react) begin
            rtime  <= sat_inc(timer);
            done_r <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
